// File: rtl/vfifo_pkg.sv
// Shared definitions for the virtual-FIFO chopper/rebuilder pair: meta layout, FSM states, keep helper.
// No logic of its own; the keep helper is pure combinational.
// Backpressure: not applicable.
package vfifo_pkg;

    localparam int BEATS_LSB = 0;
    localparam int BYTES_LSB = 8;
    localparam int META_W    = 16;
    localparam int KEEP_MAX  = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } vfifo_state_t;

    // Low n bits set; callers size-cast the result down to their own tkeep width.
    function automatic logic [KEEP_MAX-1:0] keep_from_count(input logic [7:0] n);
        logic [KEEP_MAX-1:0] k;
        for (int i = 0; i < KEEP_MAX; i++) begin
            k[i] = (i < int'(n));
        end
        return k;
    endfunction

endpackage

// File: rtl/packet_rebuilder.sv
// Merges memory burst data with per-burst meta, regenerating tkeep/tid/tdest/tlast of the original packet.
// Latency: one cycle from target handshake to initiator_tvalid; one beat per cycle across bursts.
// Backpressure: initiator_tready stalls target_tready in the same cycle via a single output register.
module packet_rebuilder
    import vfifo_pkg::*;
#(
    parameter int TDATA_BYTES   = 8,
    parameter int TKEEP_WIDTH   = TDATA_BYTES,
    parameter int TID_WIDTH     = 4,
    parameter int TDEST_WIDTH   = 1,
    parameter int MAX_BURST_LEN = 256
) (
    input  logic                     aclk,
    input  logic                     aresetn,

    input  logic                     target_tvalid,
    output logic                     target_tready,
    input  logic [8*TDATA_BYTES-1:0] target_tdata,
    input  logic                     target_tlast,

    input  logic                     meta_tvalid,
    output logic                     meta_tready,
    input  logic [META_W-1:0]        meta_tdata,
    input  logic                     meta_tlast,
    input  logic [TID_WIDTH-1:0]     meta_tid,
    input  logic [TDEST_WIDTH-1:0]   meta_tdest,

    output logic                     initiator_tvalid,
    input  logic                     initiator_tready,
    output logic [8*TDATA_BYTES-1:0] initiator_tdata,
    output logic [TKEEP_WIDTH-1:0]   initiator_tkeep,
    output logic [TID_WIDTH-1:0]     initiator_tid,
    output logic [TDEST_WIDTH-1:0]   initiator_tdest,
    output logic                     initiator_tlast,

    output logic                     err_len,
    output logic                     err_meta
);

    if (MAX_BURST_LEN < 1 || MAX_BURST_LEN > 256 || TDATA_BYTES > KEEP_MAX
        || TDATA_BYTES > 255 || TKEEP_WIDTH != TDATA_BYTES) begin : g_param_err
        $error("packet_rebuilder: unsupported parameter combination");
    end

    vfifo_state_t state_q, state_d;

    logic [7:0]             beats_m1_q;
    logic [7:0]             nbytes_q;
    logic [7:0]             beat_cnt_q;
    logic                   last_q;
    logic [TID_WIDTH-1:0]   tid_q;
    logic [TDEST_WIDTH-1:0] tdest_q;

    logic [7:0] meta_beats;
    logic [7:0] meta_nbytes;
    logic       meta_bad;
    logic       final_beat;
    logic       tgt_hs;
    logic       meta_hs;

    assign meta_beats  = meta_tdata[BEATS_LSB +: 8];
    assign meta_nbytes = meta_tdata[BYTES_LSB +: 8];
    assign meta_bad    = (meta_nbytes == 8'd0) || (meta_nbytes > 8'(TDATA_BYTES));
    assign final_beat  = (beat_cnt_q == beats_m1_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Meta is re-accepted on the final data beat so consecutive bursts flow without a bubble.
    always_comb begin
        state_d       = state_q;
        target_tready = 1'b0;
        meta_tready   = 1'b0;
        tgt_hs        = 1'b0;
        meta_hs       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                meta_tready = 1'b1;
                meta_hs     = meta_tvalid;
                if (meta_hs) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                target_tready = !initiator_tvalid || initiator_tready;
                tgt_hs        = target_tvalid && target_tready;
                meta_tready   = tgt_hs && final_beat;
                meta_hs       = meta_tvalid && meta_tready;
                if (tgt_hs && final_beat && !meta_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beats_m1_q <= 8'd0;
            nbytes_q   <= 8'd0;
            last_q     <= 1'b0;
            tid_q      <= '0;
            tdest_q    <= '0;
            beat_cnt_q <= 8'd0;
            err_meta   <= 1'b0;
        end else begin
            err_meta <= meta_hs && meta_bad;
            if (meta_hs) begin
                beats_m1_q <= meta_beats;
                nbytes_q   <= meta_bad ? 8'(TDATA_BYTES) : meta_nbytes;
                last_q     <= meta_tlast;
                tid_q      <= meta_tid;
                tdest_q    <= meta_tdest;
                beat_cnt_q <= 8'd0;
            end else if (tgt_hs) begin
                beat_cnt_q <= beat_cnt_q + 8'd1;
            end
        end
    end

    // Framing follows the meta count alone; target_tlast only feeds the length check.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            initiator_tvalid <= 1'b0;
            initiator_tdata  <= '0;
            initiator_tkeep  <= '0;
            initiator_tid    <= '0;
            initiator_tdest  <= '0;
            initiator_tlast  <= 1'b0;
            err_len          <= 1'b0;
        end else begin
            err_len <= tgt_hs && (target_tlast != final_beat);
            if (tgt_hs) begin
                initiator_tvalid <= 1'b1;
                initiator_tdata  <= target_tdata;
                initiator_tid    <= tid_q;
                initiator_tdest  <= tdest_q;
                initiator_tlast  <= final_beat && last_q;
                initiator_tkeep  <= final_beat ? TKEEP_WIDTH'(keep_from_count(nbytes_q))
                                               : {TKEEP_WIDTH{1'b1}};
            end else if (initiator_tready) begin
                initiator_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_packet_rebuilder.sv
// Directed bench for packet_rebuilder: a burst-level model predicts every output beat and error pulse.
module tb_packet_rebuilder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        target_tvalid, target_tready, target_tlast;
    logic [63:0] target_tdata;
    logic        meta_tvalid, meta_tready, meta_tlast;
    logic [15:0] meta_tdata;
    logic [3:0]  meta_tid;
    logic [0:0]  meta_tdest;
    logic        initiator_tvalid, initiator_tready, initiator_tlast;
    logic [63:0] initiator_tdata;
    logic [7:0]  initiator_tkeep;
    logic [3:0]  initiator_tid;
    logic [0:0]  initiator_tdest;
    logic        err_len, err_meta;

    packet_rebuilder #(
        .TDATA_BYTES(8), .TKEEP_WIDTH(8), .TID_WIDTH(4), .TDEST_WIDTH(1), .MAX_BURST_LEN(256)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .target_tvalid(target_tvalid), .target_tready(target_tready),
        .target_tdata(target_tdata), .target_tlast(target_tlast),
        .meta_tvalid(meta_tvalid), .meta_tready(meta_tready), .meta_tdata(meta_tdata),
        .meta_tlast(meta_tlast), .meta_tid(meta_tid), .meta_tdest(meta_tdest),
        .initiator_tvalid(initiator_tvalid), .initiator_tready(initiator_tready),
        .initiator_tdata(initiator_tdata), .initiator_tkeep(initiator_tkeep),
        .initiator_tid(initiator_tid), .initiator_tdest(initiator_tdest),
        .initiator_tlast(initiator_tlast),
        .err_len(err_len), .err_meta(err_meta)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [15:0] dat; logic last; logic [3:0] tid; logic [0:0] tdest; } meta_e;
    typedef struct { logic [63:0] dat; logic last; } data_e;
    typedef struct { logic [63:0] dat; logic [7:0] keep; logic last; logic [3:0] tid; logic [0:0] tdest; } exp_e;

    meta_e mq[$];
    data_e dq[$];
    exp_e  exq[$];

    logic [7:0] log_keep[$];
    logic       log_last[$];
    int         log_cyc[$];

    int n_pass = 0, n_total = 0;
    int exp_err_len = 0, exp_err_meta = 0;
    int obs_err_len = 0, obs_err_meta = 0;
    int cyc = 0;
    int seq = 0;
    bit rnd_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: one meta plus beats_m1+1 data beats expand into the expected output beats.
    task automatic push_burst(input int beats_m1, input int nb, input bit last,
                              input int tid, input int tdest, input int bad_beat);
        meta_e m;
        data_e d;
        exp_e  e;
        int    nb_eff;
        bit    fin;
        m.dat = {8'(nb), 8'(beats_m1)};
        m.last = last; m.tid = 4'(tid); m.tdest = 1'(tdest);
        mq.push_back(m);
        nb_eff = (nb == 0 || nb > 8) ? 8 : nb;
        if (nb_eff != nb) exp_err_meta++;
        for (int i = 0; i <= beats_m1; i++) begin
            fin   = (i == beats_m1);
            d.dat = {32'(seq), 24'hC0FFEE, 8'(i)};
            seq++;
            d.last = fin ^ (i == bad_beat);
            if (i == bad_beat) exp_err_len++;
            dq.push_back(d);
            e.dat = d.dat;
            e.keep = fin ? 8'((1 << nb_eff) - 1) : 8'hFF;
            e.last = fin && last;
            e.tid = 4'(tid); e.tdest = 1'(tdest);
            exq.push_back(e);
        end
    endtask

    task automatic clear_log();
        log_keep.delete(); log_last.delete(); log_cyc.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exq.size() > 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        check(name, exq.size(), 0);
    endtask

    initial begin : meta_drv
        bit hs;
        meta_tvalid = 1'b0; meta_tdata = '0; meta_tlast = 1'b0; meta_tid = '0; meta_tdest = '0;
        forever begin
            @(negedge aclk);
            hs = meta_tvalid && meta_tready && aresetn;
            @(posedge aclk); #1;
            if (hs && aresetn && mq.size() > 0) void'(mq.pop_front());
            if (aresetn && mq.size() > 0) begin
                meta_tvalid = 1'b1; meta_tdata = mq[0].dat; meta_tlast = mq[0].last;
                meta_tid = mq[0].tid; meta_tdest = mq[0].tdest;
            end else begin
                meta_tvalid = 1'b0;
            end
        end
    end

    initial begin : data_drv
        bit hs;
        target_tvalid = 1'b0; target_tdata = '0; target_tlast = 1'b0;
        forever begin
            @(negedge aclk);
            hs = target_tvalid && target_tready && aresetn;
            @(posedge aclk); #1;
            if (hs && aresetn && dq.size() > 0) void'(dq.pop_front());
            if (aresetn && dq.size() > 0) begin
                target_tvalid = 1'b1; target_tdata = dq[0].dat; target_tlast = dq[0].last;
            end else begin
                target_tvalid = 1'b0;
            end
        end
    end

    initial begin : ready_drv
        initiator_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            initiator_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every accepted output beat must equal the model's next beat.
    initial begin : mon
        bit          hs;
        logic [77:0] act;
        exp_e        e;
        forever begin
            @(negedge aclk);
            cyc++;
            if (aresetn && err_len)  obs_err_len++;
            if (aresetn && err_meta) obs_err_meta++;
            hs  = initiator_tvalid && initiator_tready;
            act = {initiator_tdata, initiator_tkeep, initiator_tlast, initiator_tid, initiator_tdest};
            @(posedge aclk);
            if (hs && aresetn) begin
                log_keep.push_back(act[13:6]);
                log_last.push_back(act[5]);
                log_cyc.push_back(cyc);
                if (exq.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exq.pop_front();
                    check("beat", act, {e.dat, e.keep, e.last, e.tid, e.tdest});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] kp;
        logic [7:0]  lb;
        int          base, nl;

        repeat (3) @(negedge aclk);
        check("rst_out", {initiator_tvalid, initiator_tdata, initiator_tkeep, initiator_tid,
                          initiator_tdest, initiator_tlast, err_len, err_meta}, 0);
        check("rst_target_tready", target_tready, 0);
        check("rst_meta_tready", meta_tready, 1);
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_meta_tready", meta_tready, 1);

        // 4-beat burst, 5 bytes in last beat
        clear_log();
        push_burst(3, 5, 1, 2, 1, -1);
        wait_drain("t1_drain", 100);
        kp = '0;
        lb = '0;
        for (int i = 0; i < log_keep.size() && i < 8; i++) begin
            kp = {kp[23:0], log_keep[i]};
            lb[i] = log_last[i];
        end
        check("t1_count", log_keep.size(), 4);
        check("t1_keep", kp, 32'hFFFFFF1F);
        check("t1_tlast", lb, 8'b0000_1000);

        // back-to-back bursts must not bubble
        clear_log();
        push_burst(0, 8, 0, 3, 0, -1);
        push_burst(1, 8, 1, 3, 0, -1);
        wait_drain("t2_drain", 100);
        lb = '0;
        for (int i = 0; i < log_last.size() && i < 8; i++) lb[i] = log_last[i];
        check("t2_count", log_keep.size(), 3);
        check("t2_tlast", lb, 8'b0000_0100);
        if (log_cyc.size() == 3) begin
            check("t2_gap01", log_cyc[1] - log_cyc[0], 1);
            check("t2_gap12", log_cyc[2] - log_cyc[1], 1);
        end

        // maximum burst length
        clear_log();
        push_burst(255, 8, 1, 5, 1, -1);
        wait_drain("t3_drain", 2000);
        nl = 0;
        foreach (log_last[i]) nl += int'(log_last[i]);
        check("t3_count", log_keep.size(), 256);
        check("t3_ntlast", nl, 1);
        if (log_last.size() == 256) check("t3_tlast_final", log_last[255], 1);
        check("t3_idle", {meta_tready, target_tready}, 2'b10);

        // target_tlast early on beat 2
        clear_log();
        base = obs_err_len;
        push_burst(3, 8, 1, 1, 0, 1);
        wait_drain("t4_drain", 100);
        lb = '0;
        for (int i = 0; i < log_last.size() && i < 8; i++) lb[i] = log_last[i];
        check("t4_err_len", obs_err_len - base, 1);
        check("t4_count", log_keep.size(), 4);
        check("t4_tlast", lb, 8'b0000_1000);

        // illegal byte counts fall back to a full final beat
        clear_log();
        base = obs_err_meta;
        push_burst(1, 0, 1, 0, 0, -1);
        push_burst(0, 9, 1, 0, 0, -1);
        wait_drain("t5_drain", 100);
        check("t5_err_meta", obs_err_meta - base, 2);
        if (log_keep.size() == 3) begin
            check("t5_keep_nb0", log_keep[1], 8'hFF);
            check("t5_keep_nb9", log_keep[2], 8'hFF);
        end

        // random backpressure, then reset mid-burst
        clear_log();
        rnd_ready = 1'b1;
        push_burst(20, 3, 1, 7, 1, -1);
        repeat (15) @(negedge aclk);
        #2 aresetn = 1'b0;
        @(negedge aclk);
        check("t6_progress", log_keep.size() > 0, 1);
        mq.delete(); dq.delete(); exq.delete();
        repeat (2) @(negedge aclk);
        check("t6_rst_out", {initiator_tvalid, initiator_tdata, initiator_tkeep, initiator_tid,
                             initiator_tdest, initiator_tlast, err_len, err_meta}, 0);
        check("t6_rst_rdy", {meta_tready, target_tready}, 2'b10);
        aresetn = 1'b1;
        rnd_ready = 1'b0;
        @(negedge aclk);
        check("t6_idle_after", {meta_tready, target_tready}, 2'b10);
        clear_log();
        push_burst(2, 4, 1, 1, 0, -1);
        wait_drain("t6_drain", 100);
        check("t6_count", log_keep.size(), 3);
        if (log_keep.size() == 3) check("t6_keep_final", log_keep[2], 8'h0F);

        check("err_len_total", obs_err_len, exp_err_len);
        check("err_meta_total", obs_err_meta, exp_err_meta);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/packet_rebuilder.md
# packet_rebuilder

Read-side counterpart of the virtual-FIFO write chopper. It merges a burst data stream returning from memory with its per-burst meta stream. It regenerates tkeep, tid, tdest and original-packet tlast, and emits the reassembled AXI4-Stream packet. It sits between the virtual FIFO read engine and the downstream consumer.

## Interface
- TDATA_BYTES, 8: bytes per beat.
- TKEEP_WIDTH, TDATA_BYTES: tkeep width.
- TID_WIDTH, 4: tid width.
- TDEST_WIDTH, 1: tdest width.
- MAX_BURST_LEN, 256: maximum beats per burst, range 1..256.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- target_tvalid / target_tready  in/out  1  burst data handshake.
- target_tdata  in  8*TDATA_BYTES  burst data.
- target_tlast  in  1  end-of-burst marker from the read engine; used only for the consistency check.
- meta_tvalid / meta_tready  in/out  1  meta handshake.
- meta_tdata  in  16  [7:0] burst beats minus 1; [15:8] valid bytes in the final beat (1..TDATA_BYTES).
- meta_tlast  in  1  burst ends the original packet.
- meta_tid  in  TID_WIDTH  packet tid.
- meta_tdest  in  TDEST_WIDTH  packet tdest.
- initiator_tvalid / initiator_tready  out/in  1  output handshake.
- initiator_tdata  out  8*TDATA_BYTES  data.
- initiator_tkeep  out  TKEEP_WIDTH  byte enables.
- initiator_tid  out  TID_WIDTH  tid.
- initiator_tdest  out  TDEST_WIDTH  tdest.
- initiator_tlast  out  1  original packet end.
- err_len  out  1  one-cycle pulse: target_tlast disagrees with the meta beat count.
- err_meta  out  1  one-cycle pulse: byte count is 0 or greater than TDATA_BYTES.

## Operation
- FSM has two states.
  - IDLE: waiting for meta.
  - BURST: meta held, passing data beats.
- Meta register holds beats_m1 (8b), nbytes (8b), last, tid and tdest. It loads on a meta handshake.
- meta_tready = (state==IDLE) || (state==BURST && final-beat handshake this cycle). This gives back-to-back bursts with no bubble.
- target_tready = (state==BURST) && (!initiator_tvalid || initiator_tready).
- beat_cnt (8b) clears on meta load and increments on each target handshake. The final beat is the beat where beat_cnt == beats_m1.
- Output register loads on a target handshake:
  - tdata passes through.
  - tid and tdest come from the meta register.
  - Non-final beat: tkeep all ones, tlast = 0.
  - Final beat: tkeep = low nbytes bits set, tlast = meta last.
- After the final beat the FSM returns to IDLE, or stays in BURST if the next meta loads in the same cycle.
- Framing is count-driven only. target_tlast never ends a burst early or late.
- err_len pulses when target_tlast != (final beat) on any accepted beat. Output continues unchanged.
- err_meta pulses on a meta handshake whose byte count is 0 or greater than TDATA_BYTES. That burst then uses nbytes = TDATA_BYTES.
- initiator_tvalid clears on an output handshake unless it is reloaded in the same cycle.

## Timing
- Reset values:
  - State = IDLE.
  - initiator_tvalid, err_len, err_meta, beat_cnt = 0.
  - initiator_tdata, tkeep, tid, tdest, tlast = 0.
  - meta_tready = 1 while in IDLE after reset.
  - target_tready = 0.
- Latency: one cycle from target handshake to initiator_tvalid.
- Throughput: one beat per cycle, including across burst boundaries.
- A single-beat burst (beats_m1 = 0) has its final beat as the first beat.
- beats_m1 = 255 with MAX_BURST_LEN = 256 runs 256 beats. beat_cnt must not wrap before the compare.
- beats_m1 >= MAX_BURST_LEN is not checked; the burst simply runs beats_m1+1 beats.
- Output backpressure stalls target_tready in the same cycle. No beat is lost or duplicated.
- Reset mid-burst discards the held meta and the partial burst immediately.

## Structure
- Shared package vfifo_pkg holds:
  - Meta field offsets (BEATS_LSB=0, BYTES_LSB=8, META_W=16).
  - Function keep_from_count(n), also used by the chopper for symmetry checks.
  - FSM state enum.
- No sub-module is needed. The block is a single module.

## Test plan
- Meta {beats_m1=3, nbytes=5, last=1, tid=2, tdest=1} with 4 data beats →
  - tkeep 0xFF,0xFF,0xFF,0x1F.
  - tlast on beat 4 only.
  - tid=2, tdest=1 on all beats.
- Two metas queued, {beats_m1=0, last=0} then {beats_m1=1, last=1}, with 3 beats continuously valid → 3 outputs on 3 consecutive cycles, no bubble, tlast only on beat 3.
- beats_m1=255, nbytes=8, MAX_BURST_LEN=256 → 256 beats out, tlast on beat 256, return to IDLE.
- target_tlast asserted on beat 2 of a 4-beat burst → err_len pulses one cycle, 4 beats still out, framing unchanged.
- Meta nbytes=0 → err_meta pulses, final-beat tkeep = 0xFF.
- Random initiator_tready (50%) plus reset asserted mid-burst → no loss or duplication before reset; after reset all outputs are 0 and the FSM is in IDLE.
